// File: rtl/regfile_wb_if.sv
// Register file bus: two rs/rt read ports, one writeback port, a debug read port
// and the committed-write counter.
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] R_addr_A;
  logic [ADDR_W-1:0] R_addr_B;
  logic [ADDR_W-1:0] Wt_addr;
  logic [DATA_W-1:0] Wt_data;
  logic              L_S;
  logic [DATA_W-1:0] rdata_A;
  logic [DATA_W-1:0] rdata_B;
  logic [ADDR_W-1:0] Debug_addr;
  logic [DATA_W-1:0] Debug_data;
  logic [15:0]       wr_cnt;

  modport master (
    output R_addr_A, R_addr_B, Wt_addr, Wt_data, L_S, Debug_addr,
    input  rdata_A, rdata_B, Debug_data, wr_cnt
  );

  modport slave (
    input  R_addr_A, R_addr_B, Wt_addr, Wt_data, L_S, Debug_addr,
    output rdata_A, rdata_B, Debug_data, wr_cnt
  );
endinterface

// File: rtl/regfile_wb.sv
// 32x32 MIPS register file, $0 hardwired to zero, with a committed-write counter.
// REGFILE_BYPASS_EN: when defined, ports A/B see same-cycle writeback data.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [15:0]       cnt;
  logic              wr_commit;

  // Writes to $0 are dropped entirely so they never count as commits.
  assign wr_commit = bus.L_S && (bus.Wt_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (wr_commit) begin
      regs[bus.Wt_addr] <= bus.Wt_data;
      cnt               <= cnt + 16'd1;
    end
  end

  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = (bus.R_addr_A == '0) ? '0 : regs[bus.R_addr_A];
    rd_b = (bus.R_addr_B == '0) ? '0 : regs[bus.R_addr_B];
`ifdef REGFILE_BYPASS_EN
    if (!rst && wr_commit && bus.R_addr_A == bus.Wt_addr) rd_a = bus.Wt_data;
    if (!rst && wr_commit && bus.R_addr_B == bus.Wt_addr) rd_b = bus.Wt_data;
`endif
  end

  assign bus.rdata_A    = rd_a;
  assign bus.rdata_B    = rd_b;
  assign bus.Debug_data = (bus.Debug_addr == '0) ? '0 : regs[bus.Debug_addr];
  assign bus.wr_cnt     = cnt;
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the 5-bit write-register select mux (rt/rd select), which drives Wt_addr.
- Provides two combinational read ports (rs, rt) for the decode/ALU stage.
- Provides one clocked write port from writeback and a debug read port for the board display.
- $0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width (depth = 2**ADDR_W = 32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
R_addr_A  input  5  read port A index (rs)
R_addr_B  input  5  read port B index (rt)
Wt_addr  input  5  write index, from the write-register select mux
Wt_data  input  32  writeback data
L_S  input  1  write enable (RegWrite)
rdata_A  output  32  read data for port A
rdata_B  output  32  read data for port B
Debug_addr  input  5  debug display register index
Debug_data  output  32  debug display read data
wr_cnt  output  16  count of committed writes, for the display and the bench

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: on a rising clk edge with rst=1, all registers 1..31 clear to 0 and wr_cnt clears to 0.
- rst has priority over a simultaneous write: L_S=1 in a reset cycle is discarded and wr_cnt is not incremented.
- Reads are combinational (zero latency): rdata_A = reg[R_addr_A], rdata_B = reg[R_addr_B], Debug_data = reg[Debug_addr].
- Read index 0 always returns 32'h0, regardless of any prior write attempt.
- Write is committed on the rising clk edge when L_S=1, rst=0 and Wt_addr != 0: reg[Wt_addr] <= Wt_data. The new value is visible on read ports from that edge onward.
- Write to index 0 with L_S=1 is dropped: no state change and wr_cnt is not incremented.
- wr_cnt increments by 1 on each committed write and wraps from 16'hFFFF to 16'h0000.
- Same-cycle read/write hazard (R_addr_x == Wt_addr, L_S=1) without the optional feature: the read returns the old value until the edge.
- Both read ports addressing the same index return identical data.
- Outputs after reset: rdata_A, rdata_B and Debug_data are all 0 for any index; wr_cnt = 0.
- X on Wt_data with L_S=0 must not corrupt state.
- No internal state machine beyond the register array and the write counter.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through bypass. When L_S=1, rst=0, Wt_addr != 0 and R_addr_x == Wt_addr, rdata_x returns Wt_data combinationally in the same cycle. Applies to ports A and B only; Debug_data is never bypassed.
- Undefined: no bypass; the read returns the stored (pre-edge) value.
- Storage and wr_cnt behaviour are identical in both builds.

Test Plan:
1. Reset: assert rst for 2 cycles after random writes -> all 32 indices read 0 on A, B and Debug; wr_cnt = 0.
2. Write/readback:
   - Write reg5 = 32'hDEADBEEF and reg31 = 32'h12345678.
   - Read A=5, B=31 -> 32'hDEADBEEF, 32'h12345678.
   - wr_cnt = 2.
3. $0 protection: L_S=1, Wt_addr=0, Wt_data=32'hFFFFFFFF -> reading index 0 on A, B and Debug returns 0; wr_cnt unchanged.
4. Reset priority: rst=1 with L_S=1, Wt_addr=7, Wt_data=32'hA5A5A5A5 -> reg7 = 0 after the edge; wr_cnt = 0.
5. Same-cycle hazard: reg9 = 32'h1, then L_S=1, Wt_addr=9, Wt_data=32'h2 with R_addr_A=9 in the same cycle.
   - Before the edge: rdata_A = 32'h1 without REGFILE_BYPASS_EN; 32'h2 with it.
   - After the edge: 32'h2 in both builds.
6. Counter wrap: preload via 65535 committed writes -> wr_cnt = 16'hFFFF; one more write -> wr_cnt = 0.
